// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared states and ASCII helpers for the hex UART transmitter
// Rev 1.0
// ============================================================================
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            return 8'h30 + wide;
        end
        return 8'h37 + wide;
    endfunction

    // Message character idx of a reported byte: high digit, low digit, CR, LF.
    function automatic logic [7:0] msg_char(input logic [7:0] value, input logic [1:0] idx);
        case (idx)
            2'd0:    return nibble_to_ascii(value[7:4]);
            2'd1:    return nibble_to_ascii(value[3:0]);
            2'd2:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// uart_tx_serializer : 8N1 frame generator, LSB first, registered line output
// Rev 1.0
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       line_out,
    output logic       frame_done,
    output logic       idle
);

    localparam int               CNT_W         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST_DATA = 4'd8;
    localparam logic [3:0]       BIT_STOP      = 4'd9;

    ser_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_line;
    logic             r_frame_done;

    logic w_bit_end;
    logic w_stop_next;

    assign w_bit_end = (r_cnt == CNT_LAST);

    // frame_done is registered, so flag the cycle before the last stop cycle.
    always_comb begin
        w_stop_next = 1'b0;
        if (r_state == S_STOP && !w_bit_end && (r_cnt + CNT_W'(1)) == CNT_LAST) begin
            w_stop_next = 1'b1;
        end
        if (CLKS_PER_BIT == 1 && r_state == S_DATA && r_bit == BIT_LAST_DATA) begin
            w_stop_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_line       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_stop_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_shift <= byte_in;
                        r_line  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        r_bit   <= 4'd1;
                        r_line  <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == BIT_LAST_DATA) begin
                            r_state <= S_STOP;
                            r_bit   <= BIT_STOP;
                            r_line  <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 4'd1;
                            r_line  <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        // Back-to-back frames: reload here so no idle cycle appears.
                        if (start) begin
                            r_state <= S_START;
                            r_bit   <= '0;
                            r_shift <= byte_in;
                            r_line  <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_line  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_line  <= 1'b1;
                end
            endcase
        end
    end

    assign line_out   = r_line;
    assign frame_done = r_frame_done;
    assign idle       = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_hex_tx.sv
`default_nettype none
// ============================================================================
// uart_hex_tx : reports one byte as two ASCII hex digits (+ optional CR LF)
// Rev 1.0
// ============================================================================
module uart_hex_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter bit APPEND_CRLF  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       uart_txd
);

    localparam logic [1:0] LAST_IDX = APPEND_CRLF ? 2'd3 : 2'd1;

    top_state_t r_state;
    logic [1:0] r_idx;
    logic [7:0] r_data;

    logic       w_frame_done;
    logic       w_ser_idle;
    logic       w_ser_start;
    logic       w_last_char;
    logic       w_msg_end;
    logic       w_ready;
    logic       w_accept;
    logic [7:0] w_char;

    assign w_last_char = (r_idx == LAST_IDX);
    assign w_msg_end   = (r_state == SEND) && w_frame_done && w_last_char;
    assign w_ready     = ((r_state == IDLE) && w_ser_idle) || w_msg_end;
    assign w_accept    = w_ready && data_valid;

    // LOAD is folded into the accept / frame_done cycle: the next character is
    // handed over combinationally so its start bit follows the stop bit directly.
    assign w_ser_start = w_accept || ((r_state == SEND) && w_frame_done && !w_last_char);
    assign w_char      = w_accept ? nibble_to_ascii(data[7:4])
                                  : msg_char(r_data, r_idx + 2'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data  <= data;
                        r_idx   <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_frame_done) begin
                        if (!w_last_char) begin
                            r_idx <= r_idx + 2'd1;
                        end else if (w_accept) begin
                            r_data <= data;
                            r_idx  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_ser_start),
        .byte_in   (w_char),
        .line_out  (uart_txd),
        .frame_done(w_frame_done),
        .idle      (w_ser_idle)
    );

    assign ready = w_ready;
    assign done  = w_msg_end;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_hex_tx : directed bench with a waveform model for three configurations
// Rev 1.0
// ============================================================================
module tb_uart_hex_tx;

    localparam int NI = 3;

    logic            clk = 1'b0;
    logic [2:0]      rst_n;
    logic [2:0]      valid;
    logic [2:0][7:0] din;
    logic [2:0]      txd;
    logic [2:0]      rdy;
    logic [2:0]      dn;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    bit         busy    [NI];
    bit         armed   [NI];
    int         acc_cyc [NI];
    logic [7:0] acc_dat [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_hex_tx #(.CLKS_PER_BIT(4), .APPEND_CRLF(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .data_valid(valid[0]), .data(din[0]),
        .ready(rdy[0]), .done(dn[0]), .uart_txd(txd[0]));

    uart_hex_tx #(.CLKS_PER_BIT(4), .APPEND_CRLF(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .data_valid(valid[1]), .data(din[1]),
        .ready(rdy[1]), .done(dn[1]), .uart_txd(txd[1]));

    uart_hex_tx u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .data_valid(valid[2]), .data(din[2]),
        .ready(rdy[2]), .done(dn[2]), .uart_txd(txd[2]));

    function automatic int k_of(input int i);
        return (i == 2) ? 217 : 4;
    endfunction

    function automatic int n_of(input int i);
        return (i == 1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    // Expected line level `off` cycles after the accept cycle.
    function automatic logic exp_line(input int off, input logic [7:0] d, input int k, input int n);
        int slot, ch, b;
        logic [7:0] c;
        if (off < 1 || off > n * 10 * k) return 1'b1;
        slot = (off - 1) / k;
        ch   = slot / 10;
        b    = slot % 10;
        case (ch)
            0:       c = hexc(int'(d[7:4]));
            1:       c = hexc(int'(d[3:0]));
            2:       c = 8'h0D;
            default: c = 8'h0A;
        endcase
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return c[b-1];
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic model_loop();
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                int   off, tot;
                logic e_line, e_ready, e_done;
                tot     = n_of(i) * 10 * k_of(i);
                off     = busy[i] ? (cyc - acc_cyc[i]) : 0;
                e_line  = busy[i] ? exp_line(off, acc_dat[i], k_of(i), n_of(i)) : 1'b1;
                e_done  = busy[i] && (off == tot);
                e_ready = !busy[i] || (off == tot);
                if (armed[i]) begin
                    check("model_txd",   i, {31'd0, txd[i]}, {31'd0, e_line});
                    check("model_ready", i, {31'd0, rdy[i]}, {31'd0, e_ready});
                    check("model_done",  i, {31'd0, dn[i]},  {31'd0, e_done});
                end
                if (!rst_n[i]) begin
                    armed[i] = 1'b1;
                    busy[i]  = 1'b0;
                end else if (armed[i]) begin
                    if (e_ready && valid[i]) begin
                        busy[i]    = 1'b1;
                        acc_cyc[i] = cyc;
                        acc_dat[i] = din[i];
                    end else if (busy[i] && off == tot) begin
                        busy[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic send(input int i, input logic [7:0] b, output int acc);
        @(posedge clk); #1;
        din[i]   = b;
        valid[i] = 1'b1;
        acc      = -1;
        for (int w = 0; w < 20000 && acc < 0; w++) begin
            @(negedge clk);
            if (rdy[i] === 1'b1) acc = cyc;
        end
        check("accept_seen", i, {31'd0, acc >= 0}, 32'd1);
        @(posedge clk); #1;
        valid[i] = 1'b0;
        din[i]   = ~b;
    endtask

    task automatic rx_char(input int i, output logic [7:0] c);
        int k;
        bit found;
        k     = k_of(i);
        c     = '0;
        found = 1'b0;
        for (int w = 0; w < 30 * k + 20 && !found; w++) begin
            @(negedge clk);
            if (txd[i] === 1'b0) found = 1'b1;
        end
        check("start_bit_seen", i, {31'd0, found}, 32'd1);
        repeat (k / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            repeat (k) @(negedge clk);
            c[b] = txd[i];
        end
        repeat (k) @(negedge clk);
        check("stop_bit", i, {31'd0, txd[i]}, 32'd1);
        repeat (k - 1 - k / 2) @(negedge clk);
    endtask

    task automatic run_msg(input int i, input logic [7:0] b, input logic [31:0] chars,
                           input int nchar, input int done_off);
        int         acc;
        logic [7:0] c;
        send(i, b, acc);
        for (int j = 0; j < nchar; j++) begin
            rx_char(i, c);
            check("rx_char", i, {24'd0, c}, {24'd0, chars[31 - 8*j -: 8]});
        end
        check("done_pulse", i, {31'd0, dn[i]}, 32'd1);
        check("done_cycle", i, cyc - acc, done_off);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = '0;
        valid = '0;
        din   = '0;
        fork
            model_loop();
        join_none

        repeat (2) @(posedge clk); #1;
        rst_n = '1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_txd",   i, {31'd0, txd[i]}, 32'd1);
            check("reset_ready", i, {31'd0, rdy[i]}, 32'd1);
            check("reset_done",  i, {31'd0, dn[i]},  32'd0);
        end

        // Basic message and nibble boundaries.
        run_msg(0, 8'hA5, 32'h41350D0A, 4, 160);
        run_msg(0, 8'h09, 32'h30390D0A, 4, 160);
        run_msg(0, 8'hF0, 32'h46300D0A, 4, 160);

        // Hex digits only.
        run_msg(1, 8'h3C, 32'h33430000, 2, 80);
        repeat (20) @(negedge clk);

        // Continuous valid with changing data: only accept-cycle bytes are sent.
        @(posedge clk); #1;
        valid[0] = 1'b1;
        for (int c = 0; c < 330; c++) begin
            din[0] = 8'(c * 37 + 11);
            @(posedge clk); #1;
        end
        valid[0] = 1'b0;
        repeat (200) @(posedge clk);

        // Reset in the middle of the second character's data bits.
        begin
            int acc;
            send(0, 8'hB4, acc);
            repeat (53) @(posedge clk);
            #1 rst_n[0] = 1'b0;
            @(posedge clk); #1;
            rst_n[0] = 1'b1;
            @(negedge clk);
            check("abort_txd",   0, {31'd0, txd[0]}, 32'd1);
            check("abort_ready", 0, {31'd0, rdy[0]}, 32'd1);
            check("abort_done",  0, {31'd0, dn[0]},  32'd0);
            repeat (200) @(posedge clk);
        end
        run_msg(0, 8'h7E, 32'h37450D0A, 4, 160);

        // Default bit period.
        run_msg(2, 8'h00, 32'h30300D0A, 4, 8680);
        repeat (10) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
